// File: rtl/dmem_arbiter_if.sv
// Bundle of the arbiter's core, DMA and data-memory signals.
// Latency: none (wires only). Backpressure: a denied requester holds req and its fields.
// Modports: slave = arbiter side, master = requester/memory side (used by the bench).
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  // core load/store path
  logic                  core_req;
  logic                  core_we;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic [NB-1:0]         core_be;
  logic                  core_gnt;
  logic                  core_rvalid;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic                  core_stall;

  // DMA / loader path
  logic                  dma_req;
  logic                  dma_we;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic [NB-1:0]         dma_be;
  logic                  dma_lock;
  logic                  dma_gnt;
  logic                  dma_rvalid;
  logic [DATA_WIDTH-1:0] dma_rdata;

  // single-port data memory
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [NB-1:0]         mem_we;
  logic [DATA_WIDTH-1:0] mem_rd;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_be,
    output core_gnt, core_rvalid, core_rdata, core_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_be, dma_lock,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_a, mem_wd, mem_we,
    input  mem_rd
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_be,
    input  core_gnt, core_rvalid, core_rdata, core_stall,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_be, dma_lock,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_a, mem_wd, mem_we,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between core and DMA.
// Latency: grant 0 cycles, read data 1 cycle after grant, write commits on the grant edge.
// Backpressure: loser sees no gnt (core_stall for the core) and must hold req/fields.
//
// Ports: CLK, RST_N (async active-low), bus (dmem_arbiter_if.slave): core_* and dma_*
// request/response groups plus the mem_a/mem_wd/mem_we/mem_rd memory port.
// Optional feature: define DMEM_ARB_LOCK_EN to let the DMA hold ownership via dma_lock
// for up to MAX_LOCK consecutive grants; without it dma_lock is ignored.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int MAX_LOCK   = 8
) (
  input logic            CLK,
  input logic            RST_N,
  dmem_arbiter_if.slave  bus
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

`ifdef DMEM_ARB_LOCK_EN
  localparam int LOCK_W = $clog2(MAX_LOCK + 1);
  typedef enum logic [1:0] {S_IDLE, S_CORE, S_DMA, S_DMA_LOCKED} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CORE, S_DMA} state_t;
`endif

  state_t state_q, state_d;
  logic   last_hold_q;  // owner before the most recent idle stretch (1 = DMA)
  logic   last_dma;     // round-robin pointer: 1 = DMA was granted most recently
  logic   dma_pri;      // DMA wins contention regardless of the pointer
  logic   core_win, dma_win;
  logic   core_gnt, dma_gnt;

  logic                  core_rvalid_q, dma_rvalid_q;
  logic [DATA_WIDTH-1:0] core_rdata_q, dma_rdata_q;

`ifdef DMEM_ARB_LOCK_EN
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

  // Locked ownership lasts while DMA keeps lock asserted and the run is not exhausted.
  assign dma_pri = (state_q == S_DMA_LOCKED) && bus.dma_lock &&
                   (lock_cnt_q < LOCK_W'(MAX_LOCK));
`else
  logic unused_lock;
  assign unused_lock = bus.dma_lock ^ (MAX_LOCK == 0);
  assign dma_pri     = 1'b0;
`endif

  // The state names last cycle's owner; IDLE carries no owner, so the pointer
  // falls back to the value held from before the idle stretch.
  assign last_dma = (state_q == S_IDLE) ? last_hold_q : (state_q != S_CORE);

  // Arbitration and next state.
  always_comb begin
    core_win = 1'b0;
    dma_win  = 1'b0;
    state_d  = S_IDLE;
`ifdef DMEM_ARB_LOCK_EN
    lock_cnt_d = '0;
`endif

    if (bus.core_req && bus.dma_req) begin
      if (dma_pri || !last_dma) begin
        dma_win = 1'b1;
      end else begin
        core_win = 1'b1;
      end
    end else begin
      core_win = bus.core_req;
      dma_win  = bus.dma_req;
    end

    if (core_win) begin
      state_d = S_CORE;
    end else if (dma_win) begin
      state_d = S_DMA;
`ifdef DMEM_ARB_LOCK_EN
      // A locked grant from outside the lock starts a run of 1; inside the lock it
      // extends the run. Once the run reaches MAX_LOCK the next grant drops back to
      // plain DMA, and the pointer (now DMA) hands the next contention to the core.
      if (bus.dma_lock) begin
        if (state_q != S_DMA_LOCKED) begin
          state_d    = S_DMA_LOCKED;
          lock_cnt_d = LOCK_W'(1);
        end else if (lock_cnt_q < LOCK_W'(MAX_LOCK)) begin
          state_d    = S_DMA_LOCKED;
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
`endif
    end
  end

  // No grant may escape while reset is held.
  assign core_gnt = core_win & RST_N;
  assign dma_gnt  = dma_win & RST_N;

  assign bus.core_gnt   = core_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.core_stall = bus.core_req & ~core_gnt & RST_N;

  // Memory port mux: the owner's fields pass through, otherwise everything is 0.
  always_comb begin
    bus.mem_a  = {ADDR_WIDTH{1'b0}};
    bus.mem_wd = {DATA_WIDTH{1'b0}};
    bus.mem_we = {NB{1'b0}};
    if (core_gnt) begin
      bus.mem_a  = bus.core_addr;
      bus.mem_wd = bus.core_wdata;
      bus.mem_we = bus.core_we ? bus.core_be : {NB{1'b0}};
    end else if (dma_gnt) begin
      bus.mem_a  = bus.dma_addr;
      bus.mem_wd = bus.dma_wdata;
      bus.mem_we = bus.dma_we ? bus.dma_be : {NB{1'b0}};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      last_hold_q <= 1'b1;
`ifdef DMEM_ARB_LOCK_EN
      lock_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_hold_q <= last_dma;
`ifdef DMEM_ARB_LOCK_EN
      lock_cnt_q  <= lock_cnt_d;
`endif
    end
  end

  // Read return: capture memory data for a granted load; rdata holds otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      core_rvalid_q <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      core_rdata_q  <= {DATA_WIDTH{1'b0}};
      dma_rdata_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      core_rvalid_q <= core_gnt & ~bus.core_we;
      dma_rvalid_q  <= dma_gnt & ~bus.dma_we;
      if (core_gnt && !bus.core_we) begin
        core_rdata_q <= bus.mem_rd;
      end
      if (dma_gnt && !bus.dma_we) begin
        dma_rdata_q <= bus.mem_rd;
      end
    end
  end

  assign bus.core_rvalid = core_rvalid_q;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.dma_rvalid  = dma_rvalid_q;
  assign bus.dma_rdata   = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed steps followed by randomized core/DMA traffic.
// A 512 B memory model serves mem_rd; a byte-level reference memory and a
// last-owner pointer predict grants, memory port values and read returns.
module tb_dmem_arbiter;
  localparam int MAX_LOCK = 8;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        lock;
  } req_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .ADDR_WIDTH(9),
    .DATA_WIDTH(32),
    .BYTE_WIDTH(8),
    .MAX_LOCK  (MAX_LOCK)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 37 + 11) % 256);
  endfunction

  // Physical memory: combinational read, byte writes latched mid-cycle and
  // committed on the following rising edge.
  logic [31:0] phys [128];
  assign bus.mem_rd = phys[bus.mem_a[8:2]];

  initial begin
    logic [3:0]  pw;
    logic [6:0]  pa;
    logic [31:0] pd;
    for (int w = 0; w < 128; w++)
      phys[w] = {init_byte(4*w+3), init_byte(4*w+2), init_byte(4*w+1), init_byte(4*w)};
    forever begin
      @(negedge clk);
      pw = bus.mem_we;
      pa = bus.mem_a[8:2];
      pd = bus.mem_wd;
      @(posedge clk);
      for (int i = 0; i < 4; i++)
        if (pw[i]) phys[pa][8*i +: 8] = pd[8*i +: 8];
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [512];
  logic        exp_last_dma;
  int          lock_run;
  logic        exp_crv, exp_drv;
  logic [31:0] exp_crd, exp_drd;
  logic [3:0]  dgnt_hist;
  int          stall_obs;

  function automatic logic [31:0] ref_word(input logic [8:0] a);
    int b;
    b = int'({a[8:2], 2'b00});
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic ref_write(input logic [8:0] a, input logic [31:0] wd, input logic [3:0] be);
    int b;
    b = int'({a[8:2], 2'b00});
    for (int i = 0; i < 4; i++)
      if (be[i]) ref_mem[b+i] = wd[8*i +: 8];
  endtask

  task automatic model_reset();
    exp_last_dma = 1'b1;
    lock_run     = 0;
    exp_crv      = 1'b0;
    exp_drv      = 1'b0;
    exp_crd      = 32'h0;
    exp_drd      = 32'h0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input req_t c, input req_t d);
    bus.core_req   = c.req;
    bus.core_we    = c.we;
    bus.core_addr  = c.addr;
    bus.core_wdata = c.wdata;
    bus.core_be    = c.be;
    bus.dma_req    = d.req;
    bus.dma_we     = d.we;
    bus.dma_addr   = d.addr;
    bus.dma_wdata  = d.wdata;
    bus.dma_be     = d.be;
    bus.dma_lock   = d.lock;
  endtask

  // One bus cycle, entered just after a rising edge.
  task automatic cycle(input req_t c, input req_t d, output logic cg, output logic dg);
    logic        dma_first;
    logic [8:0]  ea;
    logic [31:0] ewd;
    logic [3:0]  ewe;
    drive(c, d);
    dma_first = !exp_last_dma;
`ifdef DMEM_ARB_LOCK_EN
    if (d.lock && lock_run > 0 && lock_run < MAX_LOCK) dma_first = 1'b1;
`endif
    if (c.req && d.req) begin
      dg = dma_first;
      cg = !dma_first;
    end else begin
      cg = c.req;
      dg = d.req;
    end
    ea  = cg ? c.addr  : (dg ? d.addr  : 9'h0);
    ewd = cg ? c.wdata : (dg ? d.wdata : 32'h0);
    ewe = cg ? (c.we ? c.be : 4'h0) : (dg ? (d.we ? d.be : 4'h0) : 4'h0);

    @(negedge clk);
    chk("core_gnt",    32'(bus.core_gnt),    32'(cg));
    chk("dma_gnt",     32'(bus.dma_gnt),     32'(dg));
    chk("core_stall",  32'(bus.core_stall),  32'(c.req & ~cg));
    chk("mem_a",       32'(bus.mem_a),       32'(ea));
    chk("mem_wd",      bus.mem_wd,           ewd);
    chk("mem_we",      32'(bus.mem_we),      32'(ewe));
    chk("core_rvalid", 32'(bus.core_rvalid), 32'(exp_crv));
    chk("core_rdata",  bus.core_rdata,       exp_crd);
    chk("dma_rvalid",  32'(bus.dma_rvalid),  32'(exp_drv));
    chk("dma_rdata",   bus.dma_rdata,        exp_drd);
    dgnt_hist = {dgnt_hist[2:0], bus.dma_gnt};
    stall_obs = stall_obs + int'(bus.core_stall);

    @(posedge clk);
    #1;
    exp_crv = cg & ~c.we;
    if (exp_crv) exp_crd = ref_word(c.addr);
    exp_drv = dg & ~d.we;
    if (exp_drv) exp_drd = ref_word(d.addr);
    if (cg && c.we) ref_write(c.addr, c.wdata, c.be);
    if (dg && d.we) ref_write(d.addr, d.wdata, d.be);
    if (cg) exp_last_dma = 1'b0;
    if (dg) exp_last_dma = 1'b1;
    if (dg && d.lock) lock_run = (lock_run >= MAX_LOCK) ? 0 : lock_run + 1;
    else              lock_run = 0;
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.req   = ($urandom_range(0, 3) != 0);
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = {7'($urandom_range(0, 127)) & ($urandom_range(0, 1) != 0 ? 7'h7F : 7'h07), 2'b00};
    r.wdata = $urandom;
    r.be    = 4'($urandom_range(0, 15));
    r.lock  = 1'($urandom_range(0, 1));
    return r;
  endfunction

  initial begin
    req_t c, d, idle;
    logic cg, dg;
    idle = '0;
    model_reset();
    for (int a = 0; a < 512; a++) ref_mem[a] = init_byte(a);
    dgnt_hist = 4'h0;
    stall_obs = 0;
    drive(idle, idle);
    rst_n = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_gnt",    32'(bus.core_gnt),    32'h0);
    chk("rst_dma_gnt",     32'(bus.dma_gnt),     32'h0);
    chk("rst_core_stall",  32'(bus.core_stall),  32'h0);
    chk("rst_mem_we",      32'(bus.mem_we),      32'h0);
    chk("rst_core_rvalid", 32'(bus.core_rvalid), 32'h0);
    chk("rst_dma_rvalid",  32'(bus.dma_rvalid),  32'h0);
    chk("rst_core_rdata",  bus.core_rdata,       32'h0);
    chk("rst_dma_rdata",   bus.dma_rdata,        32'h0);
    rst_n = 1'b1;

    // Idle
    repeat (2) cycle(idle, idle, cg, dg);

    // Contention: both load for 4 cycles, core first after reset
    c = '{req: 1'b1, we: 1'b0, addr: 9'h020, wdata: 32'h0, be: 4'hF, lock: 1'b0};
    d = '{req: 1'b1, we: 1'b0, addr: 9'h040, wdata: 32'h0, be: 4'hF, lock: 1'b0};
    dgnt_hist = 4'h0;
    repeat (4) cycle(c, d, cg, dg);
    chk("contention_order", 32'(dgnt_hist), 32'h5);

    // Core half-word store, then load back
    c = '{req: 1'b1, we: 1'b1, addr: 9'h010, wdata: 32'hAABBCCDD, be: 4'b0011, lock: 1'b0};
    cycle(c, idle, cg, dg);
    c.we = 1'b0;
    cycle(c, idle, cg, dg);
    cycle(idle, idle, cg, dg);
    chk("store_lo16", 32'(bus.core_rdata[15:0]), 32'h0000CCDD);
    chk("store_hi16", 32'(bus.core_rdata[31:16]), 32'({init_byte(19), init_byte(18)}));

    // DMA writes top word, core reads it
    d = '{req: 1'b1, we: 1'b1, addr: 9'h1FC, wdata: 32'h12345678, be: 4'hF, lock: 1'b0};
    cycle(idle, d, cg, dg);
    c = '{req: 1'b1, we: 1'b0, addr: 9'h1FC, wdata: 32'h0, be: 4'hF, lock: 1'b0};
    cycle(c, idle, cg, dg);
    cycle(idle, idle, cg, dg);
    chk("dma_wr_core_rd", bus.core_rdata, 32'h12345678);

    // DMA asks for lock under contention for 12 cycles
    c = '{req: 1'b1, we: 1'b0, addr: 9'h020, wdata: 32'h0, be: 4'hF, lock: 1'b0};
    d = '{req: 1'b1, we: 1'b0, addr: 9'h044, wdata: 32'h0, be: 4'hF, lock: 1'b1};
    stall_obs = 0;
    repeat (12) cycle(c, d, cg, dg);
`ifdef DMEM_ARB_LOCK_EN
    chk("lock_stall_cycles", 32'(stall_obs), 32'd11);
`else
    chk("lock_stall_cycles", 32'(stall_obs), 32'd6);
`endif
    cycle(idle, idle, cg, dg);

    // Reset in the middle of a load: pending rvalid is cancelled
    c = '{req: 1'b1, we: 1'b0, addr: 9'h010, wdata: 32'h0, be: 4'hF, lock: 1'b0};
    cycle(c, idle, cg, dg);
    rst_n = 1'b0;
    #1;
    chk("midrst_core_rvalid", 32'(bus.core_rvalid), 32'h0);
    chk("midrst_core_rdata",  bus.core_rdata,       32'h0);
    chk("midrst_core_gnt",    32'(bus.core_gnt),    32'h0);
    chk("midrst_core_stall",  32'(bus.core_stall),  32'h0);
    chk("midrst_mem_we",      32'(bus.mem_we),      32'h0);
    model_reset();
    @(posedge clk);
    #1;
    drive(idle, idle);
    rst_n = 1'b1;
    cycle(idle, idle, cg, dg);

    // Randomized traffic honouring the hold-until-granted contract
    c = idle;
    d = idle;
    cg = 1'b1;
    dg = 1'b1;
    repeat (400) begin
      if (!c.req || cg) c = rand_req();
      if (!d.req || dg) d = rand_req();
      cycle(c, d, cg, dg);
    end
    cycle(idle, idle, cg, dg);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
